// File: rtl/wb_hazard_unit_pkg.sv
// Shared constants, forwarding select encodings and stall FSM states
// for the MEM/WB writeback and hazard unit.
`timescale 1ns/1ps
package wb_hazard_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } stall_state_e;

  // The younger EX/MEM result always wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic exmem_match, input logic memwb_match);
    if (exmem_match) begin
      return FWD_EXMEM;
    end else if (memwb_match) begin
      return FWD_MEMWB;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/wb_hazard_unit_if.sv
// Bundle of the pipeline-register fields consumed by the hazard unit and the
// values it returns to the ID and EX stages.
`timescale 1ns/1ps
interface wb_hazard_unit_if #(
  parameter int DATA_W = wb_hazard_unit_pkg::DATA_W,
  parameter int ADDR_W = wb_hazard_unit_pkg::ADDR_W,
  parameter int CNT_W  = 16
);

  logic [DATA_W-1:0] memwb_alu_res;
  logic [DATA_W-1:0] memwb_read_data;
  logic [ADDR_W-1:0] memwb_rd;
  logic              memwb_mem_to_reg;
  logic              memwb_reg_write;
  logic [ADDR_W-1:0] exmem_rd;
  logic              exmem_reg_write;
  logic [ADDR_W-1:0] idex_rs;
  logic [ADDR_W-1:0] idex_rt;
  logic              idex_mem_read;
  logic [ADDR_W-1:0] ifid_rs;
  logic [ADDR_W-1:0] ifid_rt;

  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output memwb_alu_res, memwb_read_data, memwb_rd, memwb_mem_to_reg, memwb_reg_write,
    output exmem_rd, exmem_reg_write, idex_rs, idex_rt, idex_mem_read, ifid_rs, ifid_rt,
    input  wb_data, rs_data, rt_data, fwd_a, fwd_b, stall, stall_count
  );

  modport slave (
    input  memwb_alu_res, memwb_read_data, memwb_rd, memwb_mem_to_reg, memwb_reg_write,
    input  exmem_rd, exmem_reg_write, idex_rs, idex_rt, idex_mem_read, ifid_rs, ifid_rt,
    output wb_data, rs_data, rt_data, fwd_a, fwd_b, stall, stall_count
  );

endinterface

// File: rtl/wb_hazard_unit_reg_file.sv
// 2-read/1-write register file with register 0 tied to zero and write-through
// bypass so ID sees the value being committed in the same cycle.
`timescale 1ns/1ps
module wb_hazard_unit_reg_file
  import wb_hazard_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_live;

  assign wr_live = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_live) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Bypass is independent of reset so reads track the inputs combinationally.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if (raddr_a_i == '0) begin
      rdata_a_o = '0;
    end else if (wr_live && (raddr_a_i == waddr_i)) begin
      rdata_a_o = wdata_i;
    end

    rdata_b_o = regs_q[raddr_b_i];
    if (raddr_b_i == '0) begin
      rdata_b_o = '0;
    end else if (wr_live && (raddr_b_i == waddr_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_hazard_unit.sv
// MEM/WB consumer: writeback mux, register file commit, EX forwarding selects
// and the one-cycle load-use stall with a saturating stall counter.
`timescale 1ns/1ps
module wb_hazard_unit #(
  parameter int DATA_W = wb_hazard_unit_pkg::DATA_W,
  parameter int ADDR_W = wb_hazard_unit_pkg::ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_hazard_unit_if.slave bus
);

  import wb_hazard_unit_pkg::*;

  logic [DATA_W-1:0] wb_data;
  logic              ex_valid;
  logic              wb_valid;
  logic              hit;
  logic              stall;
  stall_state_e      state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign wb_data     = bus.memwb_mem_to_reg ? bus.memwb_read_data : bus.memwb_alu_res;
  assign bus.wb_data = wb_data;

  wb_hazard_unit_reg_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (bus.memwb_reg_write),
    .waddr_i  (bus.memwb_rd),
    .wdata_i  (wb_data),
    .raddr_a_i(bus.ifid_rs),
    .raddr_b_i(bus.ifid_rt),
    .rdata_a_o(bus.rs_data),
    .rdata_b_o(bus.rt_data)
  );

  assign ex_valid  = bus.exmem_reg_write && (bus.exmem_rd != '0);
  assign wb_valid  = bus.memwb_reg_write && (bus.memwb_rd != '0);
  assign bus.fwd_a = fwd_sel(ex_valid && (bus.exmem_rd == bus.idex_rs),
                             wb_valid && (bus.memwb_rd == bus.idex_rs));
  assign bus.fwd_b = fwd_sel(ex_valid && (bus.exmem_rd == bus.idex_rt),
                             wb_valid && (bus.memwb_rd == bus.idex_rt));

  assign hit = bus.idex_mem_read && (bus.idex_rt != '0) &&
               ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

  // BUBBLE masks the stale load still visible in ID/EX after the stall cycle.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (hit) begin
          stall   = rst_n;
          state_d = BUBBLE;
        end
      end
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
    count_d = (stall && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.stall_count = count_q;

endmodule

// File: tb/tb_wb_hazard_unit.sv
// Randomised and directed bench for wb_hazard_unit against a behavioural model;
// a second instance with a 4-bit counter covers saturation.
`timescale 1ns/1ps
module tb_wb_hazard_unit;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int CW     = 16;
  localparam int CW_SAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstN;
  logic [DW-1:0] memwbAluRes, memwbReadData;
  logic [AW-1:0] memwbRd, exmemRd, idexRs, idexRt, ifidRs, ifidRt;
  logic          memwbMemToReg, memwbRegWrite, exmemRegWrite, idexMemRead;

  int unsigned total = 0;
  int unsigned bad   = 0;

  wb_hazard_unit_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW))     busMain ();
  wb_hazard_unit_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW_SAT)) busSat ();

  assign busMain.memwb_alu_res    = memwbAluRes;
  assign busMain.memwb_read_data  = memwbReadData;
  assign busMain.memwb_rd         = memwbRd;
  assign busMain.memwb_mem_to_reg = memwbMemToReg;
  assign busMain.memwb_reg_write  = memwbRegWrite;
  assign busMain.exmem_rd         = exmemRd;
  assign busMain.exmem_reg_write  = exmemRegWrite;
  assign busMain.idex_rs          = idexRs;
  assign busMain.idex_rt          = idexRt;
  assign busMain.idex_mem_read    = idexMemRead;
  assign busMain.ifid_rs          = ifidRs;
  assign busMain.ifid_rt          = ifidRt;

  assign busSat.memwb_alu_res    = memwbAluRes;
  assign busSat.memwb_read_data  = memwbReadData;
  assign busSat.memwb_rd         = memwbRd;
  assign busSat.memwb_mem_to_reg = memwbMemToReg;
  assign busSat.memwb_reg_write  = memwbRegWrite;
  assign busSat.exmem_rd         = exmemRd;
  assign busSat.exmem_reg_write  = exmemRegWrite;
  assign busSat.idex_rs          = idexRs;
  assign busSat.idex_rt          = idexRt;
  assign busSat.idex_mem_read    = idexMemRead;
  assign busSat.ifid_rs          = ifidRs;
  assign busSat.ifid_rt          = ifidRt;

  wb_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NREGS(32), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rstN),
    .bus  (busMain)
  );

  wb_hazard_unit #(.DATA_W(DW), .ADDR_W(AW), .NREGS(32), .CNT_W(CW_SAT)) dutSat (
    .clk  (clk),
    .rst_n(rstN),
    .bus  (busSat)
  );

  // Reference model: architectural register contents plus "stalled last cycle".
  logic [DW-1:0] modelRegs [32];
  bit            prevStall;
  int unsigned   modelCount, modelCountSat;

  function automatic logic [DW-1:0] expWb();
    return memwbMemToReg ? memwbReadData : memwbAluRes;
  endfunction

  function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (memwbRegWrite && (a == memwbRd)) return expWb();
    return modelRegs[a];
  endfunction

  function automatic logic [1:0] expFwd(input logic [AW-1:0] src);
    if (exmemRegWrite && (exmemRd != 0) && (exmemRd == src)) return 2'b10;
    if (memwbRegWrite && (memwbRd != 0) && (memwbRd == src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit hit;
    hit = idexMemRead && (idexRt != 0) && ((idexRt == ifidRs) || (idexRt == ifidRt));
    return rstN && hit && !prevStall;
  endfunction

  always @(posedge clk) begin
    bit s;
    if (!rstN) begin
      for (int i = 0; i < 32; i++) modelRegs[i] = '0;
      modelCount    = 0;
      modelCountSat = 0;
      prevStall     = 1'b0;
    end else begin
      s = expStall();
      if (memwbRegWrite && (memwbRd != 0)) modelRegs[memwbRd] = expWb();
      if (s && (modelCount < (2 ** CW) - 1)) modelCount++;
      if (s && (modelCountSat < (2 ** CW_SAT) - 1)) modelCountSat++;
      prevStall = s;
    end
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("wbData",     busMain.wb_data,     expWb());
    checkOutput("rsData",     busMain.rs_data,     expRead(ifidRs));
    checkOutput("rtData",     busMain.rt_data,     expRead(ifidRt));
    checkOutput("fwdA",       busMain.fwd_a,       expFwd(idexRs));
    checkOutput("fwdB",       busMain.fwd_b,       expFwd(idexRt));
    checkOutput("stall",      busMain.stall,       expStall());
    checkOutput("stallCount", busMain.stall_count, modelCount);
    checkOutput("satStall",   busSat.stall,        expStall());
    checkOutput("satCount",   busSat.stall_count,  modelCountSat);
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic stepCycle();
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    memwbAluRes = '0; memwbReadData = '0; memwbRd = '0; memwbMemToReg = 1'b0;
    memwbRegWrite = 1'b0; exmemRd = '0; exmemRegWrite = 1'b0; idexRs = '0;
    idexRt = '0; idexMemRead = 1'b0; ifidRs = '0; ifidRt = '0;
  endtask

  function automatic logic [AW-1:0] randAddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
    return AW'($urandom_range(0, 5));
  endfunction

  task automatic applyStimulus();
    rstN          = ($urandom_range(0, 31) != 0);
    memwbAluRes   = $urandom;
    memwbReadData = $urandom;
    memwbRd       = randAddr();
    memwbMemToReg = $urandom_range(0, 1);
    memwbRegWrite = ($urandom_range(0, 3) != 0);
    exmemRd       = randAddr();
    exmemRegWrite = $urandom_range(0, 1);
    idexRs        = randAddr();
    idexRt        = randAddr();
    idexMemRead   = $urandom_range(0, 1);
    ifidRs        = randAddr();
    ifidRt        = randAddr();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] pattern;
    rstN = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    stepCycle();
    rstN = 1'b1;

    memwbAluRes = 32'h11; memwbReadData = 32'h22; memwbRd = 5;
    memwbRegWrite = 1'b1; memwbMemToReg = 1'b1; ifidRs = 5;
    stepCycle();
    memwbRegWrite = 1'b0;
    #1 checkOutput("muxMemWord", busMain.rs_data, 32'h22);
    @(negedge clk);
    memwbMemToReg = 1'b0; memwbRegWrite = 1'b1;
    stepCycle();
    memwbRegWrite = 1'b0;
    #1 checkOutput("muxAluResult", busMain.rs_data, 32'h11);
    @(negedge clk);

    memwbAluRes = 32'hDEADBEEF; memwbRd = 0; memwbRegWrite = 1'b1; ifidRs = 0;
    stepCycle();
    memwbRegWrite = 1'b0;
    #1 checkOutput("reg0Zero", busMain.rs_data, 32'h0);
    @(negedge clk);

    memwbAluRes = 32'hCAFE0007; memwbRd = 7; memwbRegWrite = 1'b1; ifidRt = 7;
    #1 checkOutput("bypassRt", busMain.rt_data, 32'hCAFE0007);
    stepCycle();
    memwbRegWrite = 1'b0;
    #1 checkOutput("reg7Written", busMain.rt_data, 32'hCAFE0007);
    @(negedge clk);

    exmemRd = 3; exmemRegWrite = 1'b1; memwbRd = 3; memwbRegWrite = 1'b1;
    idexRs = 3; idexRt = 3;
    #1 checkOutput("fwdAExmemPriority", busMain.fwd_a, 2'b10);
    checkOutput("fwdBExmemPriority", busMain.fwd_b, 2'b10);
    exmemRegWrite = 1'b0;
    #1 checkOutput("fwdAMemwb", busMain.fwd_a, 2'b01);
    exmemRegWrite = 1'b1; exmemRd = 0; memwbRd = 0;
    #1 checkOutput("fwdANone", busMain.fwd_a, 2'b00);
    @(negedge clk);
    stepCycle();

    clearInputs();
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    idexMemRead = 1'b1; idexRt = 4; ifidRs = 4;
    for (int i = 0; i < 3; i++) begin
      #1 pattern[2-i] = busMain.stall;
      checkAll();
      @(negedge clk);
    end
    checkOutput("loadUsePattern", 32'(pattern), 32'b101);
    #1 checkOutput("loadUseCount", busMain.stall_count, 32'd2);
    @(negedge clk);
    idexMemRead = 1'b0;
    stepCycle();
    idexMemRead = 1'b1; idexRt = 0; ifidRs = 0; ifidRt = 0;
    #1 checkOutput("noStallRt0", busMain.stall, 1'b0);
    @(negedge clk);
    stepCycle();

    clearInputs();
    memwbRegWrite = 1'b1;
    for (int r = 1; r < 32; r++) begin
      memwbRd = AW'(r);
      memwbAluRes = DW'(r);
      stepCycle();
    end
    memwbRegWrite = 1'b0; ifidRs = 17;
    #1 checkOutput("preResetReg17", busMain.rs_data, 32'd17);
    @(negedge clk);
    idexMemRead = 1'b1; idexRt = 2; ifidRt = 2;
    stepCycle();
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1; idexMemRead = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ifidRs = AW'(a);
      ifidRt = AW'(31 - a);
      #1 checkOutput("clearedRs", busMain.rs_data, 32'h0);
      checkOutput("clearedRt", busMain.rt_data, 32'h0);
    end
    checkOutput("clearedCount", busMain.stall_count, 32'h0);
    @(negedge clk);

    rstN = 1'b0; memwbRegWrite = 1'b1; memwbRd = 9; memwbAluRes = 32'h55;
    stepCycle();
    rstN = 1'b1; memwbRegWrite = 1'b0; ifidRs = 9;
    #1 checkOutput("noWriteInReset", busMain.rs_data, 32'h0);
    @(negedge clk);

    clearInputs();
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    idexMemRead = 1'b1; idexRt = 6; ifidRt = 6;
    repeat (2 * (2 ** CW_SAT) + 5) stepCycle();
    #1 checkOutput("satHoldMain", busMain.stall_count, 32'd19);
    checkOutput("satHoldSmall", busSat.stall_count, 32'd15);
    @(negedge clk);

    clearInputs();
    rstN = 1'b0;
    stepCycle();
    rstN = 1'b1;
    repeat (400) begin
      applyStimulus();
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
